decode_queue: RTL and testbench

- Parametrised successor to the single-register superscalar decode stage.
- Decodes up to LANES instruction words per bundle into DecodeResult records (processor_help) and holds them in a DEPTH-entry bundle FIFO ahead of execute, so fetch is not stalled for every execute bubble.
- Adds a per-lane valid mask, a synchronous flush, and an occupancy output.
- Sits between fetch and execute/rename.

---
 rtl/decode_queue.sv | 147 ++++++++++++++
 tb/tb_decode_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: decodes LANES-wide instruction bundles into a DEPTH-bundle FIFO ahead of execute.
// Optional DECODE_QUEUE_UNSUPPORTED_STAT_EN adds a saturating count of valid lanes decoded UNSUPPORTED.
package processor_help;
  localparam int SUPER_SCALAR_WIDTH = 2;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    LUI = 4'd0, JAL, JALR, LOAD, STORE, BRANCH, OP_IMM_NORMAL, OP_NORMAL, OP_IMM_SHIFT, OP_SHIFT,
    UNSUPPORTED = 4'd15
  } instruction_type_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;
  typedef enum logic [2:0] {BR_EQ, BR_NEQ, BR_LT, BR_GE, BR_LTU, BR_GEU} branch_op_t;
  typedef struct packed {
    instruction_type_t instruction_type;
    alu_op_t           alu_operation;
    branch_op_t        branch_operation;
    logic [5:0]        rd;
    logic [5:0]        rs1;
    logic [5:0]        rs2;
    word_t             imm;
  } decode_result_t;
endpackage

module decode_queue import processor_help::*; #(
  parameter int LANES = SUPER_SCALAR_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              flush_in,
  output logic                              fetch_ready_out,
  input  logic                              fetch_valid_in,
  input  logic [LANES-1:0]                  fetch_lane_valid_in,
  input  logic [LANES-1:0][31:0]            fetch_data_in,
  input  logic                              execute_ready_in,
  output logic                              execute_valid_out,
  output logic [LANES-1:0]                  execute_lane_valid_out,
  output decode_result_t [LANES-1:0]        execute_payload_out,
`ifdef DECODE_QUEUE_UNSUPPORTED_STAT_EN
  output logic [15:0]                       unsupported_count_out,
`endif
  output logic [$clog2(DEPTH+1)-1:0]        occupancy_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  function automatic decode_result_t decode(input logic [24:0] w);
    decode_result_t r;
    logic [2:0] f;
    logic ok;
    f = w[6:4];
    r = '0;
    r.instruction_type = UNSUPPORTED;
    case (w[3:0])
      LUI: begin
        r.instruction_type = LUI;
        r.rd = w[9:4];
        r.imm = {7'b0, w[24:10], 10'b0};
      end
      JAL: begin
        r.instruction_type = JAL;
        r.rd = w[9:4];
        r.imm = {{17{w[24]}}, w[24:10]};
      end
      JALR, LOAD: begin
        r.instruction_type = w[0] ? LOAD : JALR;
        r.rd = w[9:4];
        r.rs1 = w[15:10];
        r.imm = {{23{w[24]}}, w[24:16]};
      end
      STORE: begin
        r.instruction_type = STORE;
        r.rs1 = w[9:4];
        r.rs2 = w[15:10];
        r.imm = {{23{w[24]}}, w[24:16]};
      end
      BRANCH: begin
        ok = f < 3'd6;
        r.instruction_type = ok ? BRANCH : UNSUPPORTED;
        r.branch_operation = ok ? branch_op_t'(f) : BR_EQ;
        r.rs1 = w[12:7];
        r.rs2 = w[18:13];
        r.imm = {{26{w[24]}}, w[24:19]};
      end
      OP_IMM_NORMAL, OP_NORMAL, OP_IMM_SHIFT, OP_SHIFT: begin
        // opcode bit 3 marks the shift group, bit 0 the register (non-immediate) form
        ok = w[3] ? f < 3'd3 : f < 3'd6;
        r.instruction_type = ok ? instruction_type_t'(w[3:0]) : UNSUPPORTED;
        r.alu_operation = !ok ? ALU_ADD : w[3] ? alu_op_t'(4'd6 + {1'b0, f}) : alu_op_t'({1'b0, f});
        r.rd = w[12:7];
        r.rs1 = w[18:13];
        if (w[0]) r.rs2 = w[24:19];
        else r.imm = {{26{w[24]}}, w[24:19]};
      end
      default: ;
    endcase
    return r;
  endfunction
  decode_result_t [LANES-1:0] dec;
  logic [LANES-1:0] unused_hi;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign dec[i] = decode(fetch_data_in[i][24:0]);
    assign unused_hi[i] = ^fetch_data_in[i][31:25];
  end
  decode_result_t [LANES-1:0] pay_mem [DEPTH];
  logic [LANES-1:0] mask_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic enq, pop;
  assign fetch_ready_out = !flush_in && (count < CW'(DEPTH) || execute_ready_in);
  assign execute_valid_out = count != '0;
  // an all-invalid bundle completes the handshake but never occupies a slot
  assign enq = fetch_valid_in && fetch_ready_out && |fetch_lane_valid_in;
  assign pop = execute_valid_out && execute_ready_in && !flush_in;
  assign execute_lane_valid_out = execute_valid_out ? mask_mem[rd_ptr] : '0;
  assign execute_payload_out = pay_mem[rd_ptr];
  assign occupancy_out = count;
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(pop);
    end
  end
  always_ff @(posedge clk_in) begin
    if (enq) begin
      pay_mem[wr_ptr] <= dec;
      mask_mem[wr_ptr] <= fetch_lane_valid_in;
    end
  end
`ifdef DECODE_QUEUE_UNSUPPORTED_STAT_EN
  logic [16:0] unsup_sum;
  always_comb begin
    unsup_sum = {1'b0, unsupported_count_out};
    for (int k = 0; k < LANES; k++)
      unsup_sum = unsup_sum + 17'(fetch_lane_valid_in[k] && dec[k].instruction_type == UNSUPPORTED);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) unsupported_count_out <= '0;
    else if (enq) unsupported_count_out <= unsup_sum[16] ? 16'hFFFF : unsup_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed checks of decode_queue with LANES=2, DEPTH=2.
module tb_decode_queue;
  import processor_help::*;
  logic clk = 0;
  logic rst, flush, fetch_ready, fetch_valid, exec_ready, exec_valid;
  logic [1:0] lane_mask, exec_lane;
  logic [1:0][31:0] data;
  decode_result_t [1:0] payload;
  logic [1:0] occ;
`ifdef DECODE_QUEUE_UNSUPPORTED_STAT_EN
  logic [15:0] unsup;
`endif
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  decode_queue #(.LANES(2), .DEPTH(2)) dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .fetch_ready_out(fetch_ready), .fetch_valid_in(fetch_valid),
    .fetch_lane_valid_in(lane_mask), .fetch_data_in(data),
    .execute_ready_in(exec_ready), .execute_valid_out(exec_valid),
    .execute_lane_valid_out(exec_lane), .execute_payload_out(payload),
`ifdef DECODE_QUEUE_UNSUPPORTED_STAT_EN
    .unsupported_count_out(unsup),
`endif
    .occupancy_out(occ)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] w_lui(input logic [5:0] rd, input logic [14:0] imm);
    return {7'b0, imm, rd, 4'd0};
  endfunction
  function automatic logic [31:0] w_jal(input logic [5:0] rd, input logic [14:0] imm);
    return {7'b0, imm, rd, 4'd1};
  endfunction
  function automatic logic [31:0] w_alu(input logic [3:0] op, input logic [2:0] f3,
                                        input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] x);
    return {7'b0, x, rs1, rd, f3, op};
  endfunction
  function automatic logic [31:0] w_br(input logic [2:0] f3, input logic [5:0] rs1,
                                       input logic [5:0] rs2, input logic [5:0] imm);
    return {7'b0, imm, rs2, rs1, f3, 4'd5};
  endfunction
  initial begin
    rst = 1; flush = 0; fetch_valid = 0; exec_ready = 0; lane_mask = 0; data = '0;
    tick; tick;
    check("rst_valid", exec_valid, 0);
    check("rst_lane", exec_lane, 0);
    check("rst_occ", occ, 0);
`ifdef DECODE_QUEUE_UNSUPPORTED_STAT_EN
    check("rst_unsup", unsup, 0);
`endif
    rst = 0;
    #1 check("rst_ready", fetch_ready, 1);
    exec_ready = 1; fetch_valid = 1; lane_mask = 2'b11;
    data[0] = w_lui(6'd5, 15'h1); data[1] = w_lui(6'd7, 15'h2);
    tick;
    check("lui_valid", exec_valid, 1);
    check("lui_occ", occ, 1);
    check("lui_type", payload[0].instruction_type, LUI);
    check("lui_rd", payload[0].rd, 5);
    check("lui_imm", payload[0].imm, 32'h400);
    check("lui_imm1", payload[1].imm, 32'h800);
    fetch_valid = 0;
    tick;
    check("lui_drain_occ", occ, 0);
    check("lui_drain_valid", exec_valid, 0);
    exec_ready = 0; fetch_valid = 1; lane_mask = 2'b01;
    data[0] = w_alu(4'd6, 3'd4, 6'd1, 6'd0, 6'd5);
    tick;
    check("fill1_occ", occ, 1);
    data[0] = w_alu(4'd7, 3'd5, 6'd2, 6'd1, 6'd7);
    tick;
    check("fill2_occ", occ, 2);
    data[0] = w_jal(6'd3, 15'h4000);
    #1 check("full_ready", fetch_ready, 0);
    tick;
    check("full_hold_occ", occ, 2);
    check("head_a_rd", payload[0].rd, 1);
    check("head_a_alu", payload[0].alu_operation, ALU_OR);
    check("head_a_imm", payload[0].imm, 5);
    exec_ready = 1;
    #1 check("full_pop_ready", fetch_ready, 1);
    tick;
    check("pushpop_full_occ", occ, 2);
    check("head_b_rd", payload[0].rd, 2);
    check("head_b_type", payload[0].instruction_type, OP_NORMAL);
    check("head_b_alu", payload[0].alu_operation, ALU_AND);
    check("head_b_rs2", payload[0].rs2, 7);
    fetch_valid = 0;
    tick;
    check("head_c_occ", occ, 1);
    check("head_c_type", payload[0].instruction_type, JAL);
    check("head_c_rd", payload[0].rd, 3);
    check("head_c_imm", payload[0].imm, 32'hFFFFC000);
    tick;
    check("order_drain_occ", occ, 0);
    exec_ready = 0; fetch_valid = 1; lane_mask = 2'b11;
    data[0] = w_alu(4'd6, 3'd0, 6'd4, 6'd3, 6'h3F);
    data[1] = w_br(3'd7, 6'd1, 6'd2, 6'd0);
    tick;
    check("addi_type", payload[0].instruction_type, OP_IMM_NORMAL);
    check("addi_alu", payload[0].alu_operation, ALU_ADD);
    check("addi_imm", payload[0].imm, 32'hFFFFFFFF);
    check("addi_rd", payload[0].rd, 4);
    check("addi_rs1", payload[0].rs1, 3);
    check("badbr_type", payload[1].instruction_type, UNSUPPORTED);
`ifdef DECODE_QUEUE_UNSUPPORTED_STAT_EN
    check("unsup_one", unsup, 1);
`endif
    data[0] = w_br(3'd2, 6'd9, 6'd10, 6'b100000);
    data[1] = w_alu(4'd9, 3'd2, 6'd11, 6'd12, 6'd13);
    tick;
    check("br_fill_occ", occ, 2);
    fetch_valid = 0; exec_ready = 1;
    tick;
    check("br_occ", occ, 1);
    check("br_type", payload[0].instruction_type, BRANCH);
    check("br_op", payload[0].branch_operation, BR_LT);
    check("br_rs1", payload[0].rs1, 9);
    check("br_rs2", payload[0].rs2, 10);
    check("br_imm", payload[0].imm, 32'hFFFFFFE0);
    check("sra_type", payload[1].instruction_type, OP_SHIFT);
    check("sra_alu", payload[1].alu_operation, ALU_SRA);
    check("sra_rd", payload[1].rd, 11);
    check("sra_rs2", payload[1].rs2, 13);
    tick;
    check("br_drain_occ", occ, 0);
    exec_ready = 0; fetch_valid = 1; lane_mask = 2'b00;
    #1 check("empty_mask_ready", fetch_ready, 1);
    tick;
    check("empty_mask_occ", occ, 0);
    check("empty_mask_valid", exec_valid, 0);
    lane_mask = 2'b01; data[0] = w_lui(6'd20, 15'h0); data[1] = 32'h0000_000F;
    tick;
    lane_mask = 2'b10; data[1] = w_lui(6'd21, 15'h0);
    tick;
    check("flush_fill_occ", occ, 2);
    check("flush_head_lane", exec_lane, 2'b01);
    check("flush_head_rd", payload[0].rd, 20);
    check("invalid_lane_type", payload[1].instruction_type, UNSUPPORTED);
`ifdef DECODE_QUEUE_UNSUPPORTED_STAT_EN
    check("invalid_lane_unsup", unsup, 1);
`endif
    flush = 1; exec_ready = 1;
    #1 check("flush_ready", fetch_ready, 0);
    tick;
    flush = 0; fetch_valid = 0;
    check("flush_occ", occ, 0);
    check("flush_valid", exec_valid, 0);
    check("flush_lane", exec_lane, 0);
`ifdef DECODE_QUEUE_UNSUPPORTED_STAT_EN
    check("flush_unsup", unsup, 1);
`endif
    tick;
    check("flush_no_stale", exec_valid, 0);
    exec_ready = 0; fetch_valid = 1; lane_mask = 2'b01; data[0] = w_lui(6'd30, 15'h0);
    tick;
    check("midrst_occ", occ, 1);
    rst = 1; data[0] = w_lui(6'd31, 15'h3);
    tick;
    rst = 0;
    check("midrst_after_occ", occ, 0);
    check("midrst_after_valid", exec_valid, 0);
    check("midrst_after_lane", exec_lane, 0);
`ifdef DECODE_QUEUE_UNSUPPORTED_STAT_EN
    check("midrst_unsup", unsup, 0);
`endif
    exec_ready = 1;
    tick;
    check("fresh_occ", occ, 1);
    check("fresh_rd", payload[0].rd, 31);
    check("fresh_imm", payload[0].imm, 32'hC00);
    data[0] = w_lui(6'd32, 15'h0);
    tick;
    check("pushpop_one_occ", occ, 1);
    check("pushpop_one_rd", payload[0].rd, 32);
    fetch_valid = 0;
    tick;
    check("final_occ", occ, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
